// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU with a bit-serial multi-cycle shifter and registered result/flags
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  ALUsel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zf,
    output logic        cf,
    output logic        vf,
    output logic        sf,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      state, state_next;
    logic [3:0]  op;
    logic [4:0]  cnt;
    logic [31:0] sreg, sh_next, alu_res, bb;
    logic [32:0] sum;
    logic        is_sub, arith, is_shift, alu_c, alu_v;
    assign busy = (state == SHIFT);
    always_comb begin
        is_sub   = (ALUsel == ALU_SUB);
        arith    = (ALUsel == ALU_ADD) || is_sub;
        is_shift = (ALUsel == ALU_SLL) || (ALUsel == ALU_SRL) || (ALUsel == ALU_SRA);
        bb       = is_sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, bb} + {32'b0, is_sub};
        alu_c    = arith & sum[32];
        alu_v    = arith & (a[31] == bb[31]) & (sum[31] != a[31]);
        // zero-amount shifts fall through here and return a unchanged
        alu_res  = arith                 ? sum[31:0] :
                   (ALUsel == ALU_AND)   ? a & b :
                   (ALUsel == ALU_OR)    ? a | b :
                   (ALUsel == ALU_XOR)   ? a ^ b :
                   (ALUsel == ALU_SLT)   ? {31'b0, $signed(a) < $signed(b)} :
                   (ALUsel == ALU_SLTU)  ? {31'b0, a < b} :
                   is_shift              ? a : b;
        sh_next  = (op == ALU_SLL) ? {sreg[30:0], 1'b0} : {(op == ALU_SRA) & sreg[31], sreg[31:1]};
        state_next = state;
        if (state == IDLE && start && is_shift && b[4:0] != 5'd0)
            state_next = SHIFT;
        else if (state == SHIFT && cnt == 5'd1)
            state_next = IDLE;
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            cnt    <= '0;
            sreg   <= '0;
            result <= '0;
            {zf, cf, vf, sf} <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                if (state_next == SHIFT) begin
                    op   <= ALUsel;
                    sreg <= a;
                    cnt  <= b[4:0];
                end else begin
                    result <= alu_res;
                    {zf, cf, vf, sf} <= {alu_res == 32'd0, alu_c, alu_v, alu_res[31]};
                    done <= 1'b1;
                end
            end else if (state == SHIFT) begin
                sreg <= sh_next;
                cnt  <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    result <= sh_next;
                    {zf, cf, vf, sf} <= {sh_next == 32'd0, 2'b00, sh_next[31]};
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table plus hand-written shift/reset/back-to-back sequences, checked via a scoreboard queue
module tb_alu_exec_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]  ALUsel = '0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] result;
    logic        zf, cf, vf, sf, busy, done;
    int          checks = 0, errors = 0;
    typedef struct packed { logic [31:0] r; logic [3:0] f; } exp_t;
    typedef struct { logic [3:0] sel; logic [31:0] a, b, r; logic [3:0] f; } vec_t;
    exp_t q[$];
    vec_t vt[15];
    alu_exec_unit dut (
        .clk(clk), .rst(rst), .start(start), .ALUsel(ALUsel), .a(a), .b(b),
        .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask
    // scoreboard: every done pops the oldest expectation ({zf,cf,vf,sf} order)
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 want no pending op at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.r);
                chk("flags_zcvs", {28'b0, zf, cf, vf, sf}, {28'b0, e.f});
            end
        end
    end
    task automatic run_op(input logic [3:0] sel, input logic [31:0] oa, ob, er,
                          input logic [3:0] ef, input int elat, input bit poke);
        int lat, bc;
        @(negedge clk);
        ALUsel = sel; a = oa; b = ob; start = 1'b1;
        q.push_back('{er, ef});
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; ALUsel = 4'($urandom);
        lat = 1; bc = 0;
        while (!done && lat < 200) begin
            bc += int'(busy);
            if (poke) start = (lat == 2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, elat);
        chk("busy_cycles", bc, elat - 1);
    endtask
    initial begin
        vt[0]  = '{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011};
        vt[1]  = '{4'd1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1100};
        vt[2]  = '{4'd6, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000};
        vt[3]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100};
        vt[4]  = '{4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0001};
        vt[5]  = '{4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0110};
        vt[6]  = '{4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0001};
        vt[7]  = '{4'd3, 32'h00000000, 32'h00000000, 32'h00000000, 4'b1000};
        vt[8]  = '{4'd4, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'b0001};
        vt[9]  = '{4'd5, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4'b0000};
        vt[10] = '{4'd5, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
        vt[11] = '{4'd10, 32'h00000123, 32'h80000000, 32'h80000000, 4'b0001};
        vt[12] = '{4'd15, 32'h00000777, 32'h00001234, 32'h00001234, 4'b0000};
        vt[13] = '{4'd7, 32'h00000001, 32'h00000020, 32'h00000001, 4'b0000};
        vt[14] = '{4'd9, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0001};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {result[31:6], zf, cf, vf, sf, busy, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++)
            run_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].r, vt[i].f, 1, 1'b0);
        run_op(4'd9, 32'h80000000, 32'd4, 32'hF8000000, 4'b0001, 5, 1'b1);
        run_op(4'd8, 32'hFFFFFFFF, 32'd31, 32'h00000001, 4'b0000, 32, 1'b0);
        run_op(4'd7, 32'h00000003, 32'd4, 32'h00000030, 4'b0000, 5, 1'b0);
        // abort an SLL on its third busy cycle, with a competing start under reset
        @(negedge clk);
        ALUsel = 4'd7; a = 32'h1; b = 32'd10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_abort", {31'b0, busy}, 32'd1);
        rst = 1'b1; start = 1'b1; ALUsel = 4'd0; a = 32'd7; b = 32'd8;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("abort_outputs", {result[31:6], zf, cf, vf, sf, busy, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_done", {30'b0, busy, done}, 32'd0);
        end
        run_op(4'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1, 1'b0);
        // three starts on consecutive edges must give three consecutive done cycles
        @(negedge clk);
        ALUsel = 4'd4; a = 32'h0F0F1234; b = 32'h00FF00FF; start = 1'b1;
        q.push_back('{32'h0FF012CB, 4'b0000});
        @(negedge clk);
        chk("b2b_done0", {31'b0, done}, 32'd1);
        ALUsel = 4'd5; a = 32'hFFFFFFFF; b = 32'h0;
        q.push_back('{32'h00000001, 4'b0000});
        @(negedge clk);
        chk("b2b_done1", {31'b0, done}, 32'd1);
        ALUsel = 4'd14; a = 32'hDEADBEEF; b = 32'h1234;
        q.push_back('{32'h00001234, 4'b0000});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", {31'b0, done}, 32'd1);
        @(negedge clk);
        chk("b2b_idle", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 ALUsel  input  4  operation select from ALU_control; encodings per the `ALU_* macros in defines.v.
REQ-006 a  input  32  operand A (rs1 value).
REQ-007 b  input  32  operand B (rs2 value or immediate); shift amount is b[4:0].
REQ-008 result  output  32  registered result; held stable until the next done.
REQ-009 zf, cf, vf, sf  output  1 each  registered zero, carry, overflow and sign flags.
REQ-010 busy  output  1  high while a multi-cycle shift is in progress.
REQ-011 done  output  1  one-cycle pulse marking that result and flags are valid and updated.

Function
REQ-012 The FSM SHALL have states IDLE and SHIFT; busy = (state == SHIFT).
REQ-013 In IDLE with start=1 at edge E0, the block SHALL latch ALUsel, a and b; start in SHIFT SHALL be ignored.
REQ-014 Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLTU, PASS): result and flags written at E0; done=1 in the cycle after E0; state stays IDLE.
REQ-015 ADD: a+b; SUB: a+~b+1 computed 33 bits wide; cf = bit 32 of that sum; vf = signed overflow of the add/sub; sf = result[31]; zf = (result == 0).
REQ-016 For non-ADD/SUB ops, zf and sf SHALL follow the result, and cf and vf SHALL be 0.
REQ-017 SLT: result = {31'b0, signed(a) < signed(b)}; SLTU: same comparison but unsigned; PASS: result = b.
REQ-018 Any unassigned ALUsel encoding SHALL behave as PASS.
REQ-019 SLL, SRL and SRA with b[4:0] = 0 SHALL complete as single-cycle ops with result = a.
REQ-020 SLL, SRL and SRA with n = b[4:0] > 0: at E0, load a shift register with a and a counter with n, then go to SHIFT.
REQ-021 In SHIFT, each edge SHALL shift by one bit (SLL: zero-fill LSB; SRL: zero-fill MSB; SRA: replicate bit 31) and decrement the counter.
REQ-022 On the edge where the counter goes 1 to 0, the block SHALL write result and flags, return to IDLE, and pulse done in the following cycle.
REQ-023 For shifts, done SHALL appear n cycles later than for single-cycle ops, and busy SHALL be high for exactly n cycles.
REQ-024 A start arriving in the same cycle that busy falls (IDLE reached) SHALL be accepted at the next edge; back-to-back single-cycle ops SHALL sustain one per cycle.
REQ-025 Operand and ALUsel inputs SHALL be don't-care except at the accepting edge.
REQ-026 result and flags SHALL change only on an edge that also raises done.

Reset
REQ-027 While rst=1 at an edge: state=IDLE; result=0; zf=cf=vf=sf=0; busy=0; done=0; counter and shift register cleared.
REQ-028 rst during SHIFT SHALL abort the operation with no done pulse, and result SHALL read 0 afterwards.
REQ-029 rst SHALL take priority over start in the same cycle.

Verification
REQ-030 ADD a=0x7FFFFFFF, b=1 -> done 1 cycle after accept, result=0x80000000, vf=1, sf=1, cf=0, zf=0.
REQ-031 SUB a=5, b=5 -> result=0, zf=1, cf=1, vf=0; then SLTU a=1, b=0xFFFFFFFF -> result=1, cf=0, vf=0.
REQ-032 SRA a=0x80000000, b=4 -> busy high for 4 cycles, done 4 cycles later than a single-cycle op, result=0xF8000000; start pulsed during busy is ignored.
REQ-033 SLL a=0x1, b=0x20 (shamt 0) -> single-cycle, result=0x1; SRL a=0xFFFFFFFF, b=31 -> result=0x1 after 31 busy cycles.
REQ-034 rst asserted on the 3rd busy cycle of SLL with b=10 -> no done pulse, all outputs 0; next ADD 2+3 -> result=5.
REQ-035 Back-to-back starts for XOR, SLT(a=-1, b=0) and an unassigned ALUsel (b=0x1234) -> three consecutive done cycles with results a^b, 1 and 0x1234.
